// File: rtl/adc_capture_buffer.sv
// rtl/adc_capture_buffer.sv - Triggered, decimating ADC capture buffer with valid/ready readout
//
// Arms on a command pulse, starts on a fresh trigger rising edge, stores every
// (decim+1)-th ADC sample into on-chip RAM until n_samples are held, then
// streams them out as 16-bit words or 8-bit bytes over a valid/ready port.
//
// Ports:
//   mainclk    - system clock, rising edge
//   rstb       - asynchronous active-low reset
//   arm        - one-cycle arm pulse, honoured only in IDLE
//   abort      - synchronous abort, highest priority, any state
//   trigger    - trigger level, a 0->1 edge in ARMED starts capture
//   adc_valid  - one-cycle strobe per converted sample
//   adc_data   - ADC sample, qualified by adc_valid
//   decim      - keep one sample in (decim+1), latched on arm
//   n_samples  - samples to capture (0 or > DEPTH means DEPTH), latched on arm
//   out_mode   - 0: 16-bit words, 1: 8-bit bytes (high byte first), latched on arm
//   rd_ready   - consumer ready
//   rd_valid   - rd_data valid
//   rd_data    - output word (zero when rd_valid is low)
//   data_ready - buffer filled, readout pending or in progress
//   state      - FSM state: IDLE=0, ARMED=1, CAPTURE=2, READOUT=3
//   arm_err    - sticky flag, arm seen outside IDLE; cleared by abort or reset
//
// Build option CAPTURE_HEADER_EN: readout starts with one header word
// {out_mode, 3'b101, n_latched[11:0]} (two bytes in 8-bit mode).

module adc_capture_buffer #(
  parameter int ADC_W   = 14,
  parameter int DEPTH   = 128,
  parameter int AW      = $clog2(DEPTH),
  parameter int DECIM_W = 8
) (
  input  logic               mainclk,
  input  logic               rstb,
  input  logic               arm,
  input  logic               abort,
  input  logic               trigger,
  input  logic               adc_valid,
  input  logic [ADC_W-1:0]   adc_data,
  input  logic [DECIM_W-1:0] decim,
  input  logic [AW:0]        n_samples,
  input  logic               out_mode,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [15:0]        rd_data,
  output logic               data_ready,
  output logic [1:0]         state,
  output logic               arm_err
);

`ifdef CAPTURE_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_READOUT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               trig_q, trig_d;
  logic [DECIM_W-1:0] decim_q, decim_d;
  logic               out_mode_q, out_mode_d;
  logic [AW:0]        n_q, n_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [DECIM_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [AW+2:0]      widx_q, widx_d;
  logic               start_q, start_d;
  logic               rd_valid_q, rd_valid_d;
  logic               data_ready_q, data_ready_d;
  logic               arm_err_q, arm_err_d;

  logic               mem_we;
  logic [ADC_W-1:0]   mem [DEPTH];
  logic [ADC_W-1:0]   ram_rdata_q;

  // Output word index -> (unit, byte) -> sample address. A unit is one
  // 16-bit quantity (header or sample); in byte mode each unit spans two words.
  logic [AW+1:0]      unit_idx;
  logic [AW+1:0]      samp_idx;
  logic [AW-1:0]      rd_addr;
  logic               byte_lo;
  logic [15:0]        word16;
  logic [15:0]        word_out;
  logic [AW+2:0]      base_words;
  logic [AW+2:0]      total_words;
  logic               last_word;
  logic               unused_addr_bits;

  assign unit_idx    = out_mode_q ? widx_q[AW+2:1] : widx_q[AW+1:0];
  assign byte_lo     = out_mode_q & widx_q[0];
  assign samp_idx    = unit_idx - (AW+2)'(HDR);
  assign rd_addr     = samp_idx[AW-1:0];
  assign unused_addr_bits = ^samp_idx[AW+1:AW];

`ifdef CAPTURE_HEADER_EN
  logic [15:0] n_ext;
  logic [15:0] header;
  assign n_ext  = 16'(n_q);
  assign header = {out_mode_q, 3'b101, n_ext[11:0]};
  assign word16 = (unit_idx == '0) ? header : 16'(ram_rdata_q);
`else
  assign word16 = 16'(ram_rdata_q);
`endif

  assign word_out    = out_mode_q ? {8'h00, (byte_lo ? word16[7:0] : word16[15:8])} : word16;
  assign base_words  = (AW+3)'(n_q) + (AW+3)'(HDR);
  assign total_words = out_mode_q ? {base_words[AW+1:0], 1'b0} : base_words;
  assign last_word   = (widx_q == total_words - (AW+3)'(1));

  // RAM: write port from capture, registered read addressed by the word index.
  // The address only moves on a transfer, so the registered output stays put
  // under backpressure and is current one cycle after each transfer.
  always_ff @(posedge mainclk) begin
    if (mem_we) begin
      mem[wr_ptr_q[AW-1:0]] <= adc_data;
    end
    ram_rdata_q <= mem[rd_addr];
  end

  always_ff @(posedge mainclk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= S_IDLE;
      trig_q       <= 1'b0;
      decim_q      <= '0;
      out_mode_q   <= 1'b0;
      n_q          <= '0;
      wr_ptr_q     <= '0;
      dec_cnt_q    <= '0;
      widx_q       <= '0;
      start_q      <= 1'b0;
      rd_valid_q   <= 1'b0;
      data_ready_q <= 1'b0;
      arm_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_q       <= trig_d;
      decim_q      <= decim_d;
      out_mode_q   <= out_mode_d;
      n_q          <= n_d;
      wr_ptr_q     <= wr_ptr_d;
      dec_cnt_q    <= dec_cnt_d;
      widx_q       <= widx_d;
      start_q      <= start_d;
      rd_valid_q   <= rd_valid_d;
      data_ready_q <= data_ready_d;
      arm_err_q    <= arm_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    trig_d       = trigger;
    decim_d      = decim_q;
    out_mode_d   = out_mode_q;
    n_d          = n_q;
    wr_ptr_d     = wr_ptr_q;
    dec_cnt_d    = dec_cnt_q;
    widx_d       = widx_q;
    start_d      = start_q;
    rd_valid_d   = rd_valid_q;
    data_ready_d = data_ready_q;
    arm_err_d    = arm_err_q;
    mem_we       = 1'b0;

    if (abort) begin
      state_d      = S_IDLE;
      wr_ptr_d     = '0;
      dec_cnt_d    = '0;
      widx_d       = '0;
      start_d      = 1'b0;
      rd_valid_d   = 1'b0;
      data_ready_d = 1'b0;
      arm_err_d    = 1'b0;
    end else begin
      if (arm && (state_q != S_IDLE)) begin
        arm_err_d = 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            decim_d    = decim;
            out_mode_d = out_mode;
            n_d        = ((n_samples == '0) || (n_samples > DEPTH_N)) ? DEPTH_N : n_samples;
            state_d    = S_ARMED;
          end
        end
        S_ARMED: begin
          // trig_q holds last cycle's level, so a trigger already high at
          // arm time produces no edge here.
          if (trigger && !trig_q) begin
            state_d   = S_CAPTURE;
            wr_ptr_d  = '0;
            dec_cnt_d = '0;
          end
        end
        S_CAPTURE: begin
          if (adc_valid) begin
            if (dec_cnt_q == '0) begin
              mem_we    = 1'b1;
              wr_ptr_d  = wr_ptr_q + (AW+1)'(1);
              dec_cnt_d = decim_q;
              if (wr_ptr_q + (AW+1)'(1) == n_q) begin
                state_d      = S_READOUT;
                data_ready_d = 1'b1;
                widx_d       = '0;
                start_d      = 1'b1;
              end
            end else begin
              dec_cnt_d = dec_cnt_q - DECIM_W'(1);
            end
          end
        end
        S_READOUT: begin
          // start_q spends the first cycle letting the RAM register word 0.
          if (start_q) begin
            start_d = 1'b0;
          end else if (!rd_valid_q) begin
            rd_valid_d = 1'b1;
          end else if (rd_ready) begin
            rd_valid_d = 1'b0;
            if (last_word) begin
              state_d      = S_IDLE;
              data_ready_d = 1'b0;
              widx_d       = '0;
              wr_ptr_d     = '0;
            end else begin
              widx_d = widx_q + (AW+3)'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_valid_q ? word_out : 16'h0000;
  assign data_ready = data_ready_q;
  assign state      = state_q;
  assign arm_err    = arm_err_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// tb/tb_adc_capture_buffer.sv - Self-checking bench for adc_capture_buffer

module tb_adc_capture_buffer;
  localparam int ADC_W   = 14;
  localparam int DEPTH   = 128;
  localparam int AW      = 7;
  localparam int DECIM_W = 8;

  logic               mainclk = 1'b0;
  logic               rstb = 1'b0;
  logic               arm = 1'b0;
  logic               abort = 1'b0;
  logic               trigger = 1'b0;
  logic               adc_valid = 1'b0;
  logic [ADC_W-1:0]   adc_data = '0;
  logic [DECIM_W-1:0] decim = '0;
  logic [AW:0]        n_samples = '0;
  logic               out_mode = 1'b0;
  logic               rd_ready = 1'b0;
  logic               rd_valid;
  logic [15:0]        rd_data;
  logic               data_ready;
  logic [1:0]         state;
  logic               arm_err;

  int total = 0;
  int bad   = 0;

  logic [15:0] stream_q[$];
  logic [15:0] fixed_q[$];
  logic [15:0] exp_q[$];

  adc_capture_buffer #(
    .ADC_W(ADC_W), .DEPTH(DEPTH), .AW(AW), .DECIM_W(DECIM_W)
  ) dut (
    .mainclk(mainclk), .rstb(rstb), .arm(arm), .abort(abort), .trigger(trigger),
    .adc_valid(adc_valid), .adc_data(adc_data), .decim(decim), .n_samples(n_samples),
    .out_mode(out_mode), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .data_ready(data_ready), .state(state), .arm_err(arm_err)
  );

  always #5 mainclk = ~mainclk;

  task automatic tick();
    @(posedge mainclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_n(input int n);
    return ((n == 0) || (n > DEPTH)) ? DEPTH : n;
  endfunction

  function automatic void push_word(input logic [15:0] w, input bit mode);
    if (mode) begin
      exp_q.push_back({8'h00, w[15:8]});
      exp_q.push_back({8'h00, w[7:0]});
    end else begin
      exp_q.push_back(w);
    end
  endfunction

  // Reference: keep every (dv+1)-th sample of the fed stream starting with
  // the first, up to nl samples; optional header leads.
  function automatic void build_expected(input int dv, input int nl, input bit mode);
    int kept;
    logic [15:0] h;
    kept = 0;
    exp_q.delete();
`ifdef CAPTURE_HEADER_EN
    h = {mode, 3'b101, 12'(nl)};
    push_word(h, mode);
`else
    h = 16'h0000;
`endif
    foreach (stream_q[i]) begin
      if (((i % (dv + 1)) == 0) && (kept < nl)) begin
        push_word(stream_q[i], mode);
        kept++;
      end
    end
  endfunction

  task automatic do_arm(input int n, input int dv, input bit mode);
    n_samples = (AW+1)'(n);
    decim     = DECIM_W'(dv);
    out_mode  = mode;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("arm_state", 32'(state), 32'd1);
  endtask

  task automatic start_capture();
    stream_q.delete();
    trigger = 1'b0;
    tick();
    trigger = 1'b1;
    tick();
    check("cap_start", 32'(state), 32'd2);
    trigger = 1'b0;
  endtask

  task automatic feed_one();
    logic [15:0] s;
    if (fixed_q.size() > 0) s = fixed_q.pop_front();
    else s = 16'($urandom_range(0, 16383));
    stream_q.push_back(s);
    adc_valid = 1'b1;
    adc_data  = s[ADC_W-1:0];
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic feed_capture(input int budget);
    int gap;
    for (int c = 0; c < budget; c++) begin
      feed_one();
      if (state != 2'd2) break;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
    end
    check("cap_done_state", 32'(state), 32'd3);
    check("cap_data_ready", 32'(data_ready), 32'd1);
  endtask

  task automatic read_all(input int idx0, input int gap0, input int pct);
    int idx;
    int gap;
    bit rdy, xfer, hold, done;
    logic [15:0] held;
    idx = idx0;
    gap = gap0;
    done = 1'b0;
    for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
      if (gap == 1) check("gap_low", 32'(rd_valid), 32'd0);
      if (gap == 2) check("gap_high", 32'(rd_valid), 32'd1);
      rdy  = ($urandom_range(0, 99) < pct);
      rd_ready = rdy;
      xfer = rd_valid && rdy;
      hold = rd_valid && !rdy;
      held = rd_data;
      if (xfer) begin
        check("dr_during_read", 32'(data_ready), 32'd1);
        check("rd_word", 32'(rd_data), 32'(exp_q[idx]));
        idx++;
      end
      tick();
      if (hold) begin
        check("hold_valid", 32'(rd_valid), 32'd1);
        check("hold_data", 32'(rd_data), 32'(held));
      end
      if (xfer) gap = 1;
      else if (gap > 0) gap++;
      if (xfer && (idx == exp_q.size())) begin
        done = 1'b1;
        check("end_state", 32'(state), 32'd0);
        check("end_data_ready", 32'(data_ready), 32'd0);
        check("end_rd_valid", 32'(rd_valid), 32'd0);
      end
    end
    rd_ready = 1'b0;
    check("rd_complete", 32'(idx), 32'(exp_q.size()));
  endtask

  task automatic wait_rd_valid();
    for (int c = 0; c < 10 && !rd_valid; c++) tick();
    check("wait_rd_valid", 32'(rd_valid), 32'd1);
  endtask

  task automatic check_aborted(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_data_ready"}, 32'(data_ready), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_arm_err"}, 32'(arm_err), 32'd0);
  endtask

  initial begin
    int n, dv, nl;
    bit m;
    logic [15:0] d;

    // Reset state
    tick();
    tick();
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_data_ready", 32'(data_ready), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_arm_err", 32'(arm_err), 32'd0);
    rstb = 1'b1;
    tick();

    // Basic 16-bit capture with exact readout latency
    do_arm(4, 0, 1'b0);
    start_capture();
    fixed_q = '{16'h0001, 16'h0002, 16'h3FFF, 16'h2000};
    feed_capture(20);
    check("basic_rv_e0", 32'(rd_valid), 32'd0);
    tick();
    check("basic_rv_e1", 32'(rd_valid), 32'd0);
    tick();
    check("basic_rv_e2", 32'(rd_valid), 32'd1);
    build_expected(0, 4, 1'b0);
    read_all(0, 0, 100);

    // Decimation + byte mode
    do_arm(2, 2, 1'b1);
    start_capture();
    fixed_q = '{16'h1234, 16'h0001, 16'h0002, 16'h0ABC, 16'h0003};
    feed_capture(20);
    check("decim_stream_len", 32'(stream_q.size()), 32'd4);
    fixed_q.delete();
    build_expected(2, 2, 1'b1);
    read_all(0, 0, 100);

    // Backpressure: hold ready low 10 cycles
    do_arm(3, 1, 1'b0);
    start_capture();
    feed_capture(40);
    build_expected(1, 3, 1'b0);
    wait_rd_valid();
    rd_ready = 1'b0;
    d = rd_data;
    check("bp_first_word", 32'(d), 32'(exp_q[0]));
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_valid", 32'(rd_valid), 32'd1);
      check("bp_stable", 32'(rd_data), 32'(d));
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("bp_released", 32'(rd_valid), 32'd0);
    read_all(1, 1, 100);

    // Trigger already high at arm; arm during capture
    trigger = 1'b1;
    do_arm(4, 0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      adc_valid = 1'b1;
      tick();
      adc_valid = 1'b0;
      check("trig_high_no_start", 32'(state), 32'd1);
    end
    trigger = 1'b0;
    tick();
    check("trig_low_armed", 32'(state), 32'd1);
    stream_q.delete();
    trigger = 1'b1;
    tick();
    check("trig_edge_start", 32'(state), 32'd2);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("arm_err_set", 32'(arm_err), 32'd1);
    check("arm_in_cap_state", 32'(state), 32'd2);
    feed_capture(20);
    trigger = 1'b0;
    build_expected(0, 4, 1'b0);
    read_all(0, 0, 70);
    check("arm_err_sticky", 32'(arm_err), 32'd1);

    // Abort after 2 of 4 samples
    do_arm(4, 0, 1'b0);
    start_capture();
    feed_one();
    feed_one();
    check("abort_cap_pre", 32'(state), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_aborted("abort_cap");

    // Abort mid-readout
    do_arm(3, 0, 1'b1);
    start_capture();
    feed_capture(20);
    wait_rd_valid();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_aborted("abort_rd");

    // Abort and arm together: abort wins in IDLE and in ARMED
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    check_aborted("abort_arm_idle");
    do_arm(5, 0, 1'b0);
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    check_aborted("abort_arm_armed");

    // n=0 clamps to full depth
    do_arm(0, 0, 1'b0);
    start_capture();
    feed_capture(2000);
    check("n0_stream_len", 32'(stream_q.size()), 32'(DEPTH));
    build_expected(0, DEPTH, 1'b0);
    read_all(0, 0, 80);

    // Randomised runs, including an oversize n
    for (int r = 0; r < 6; r++) begin
      n  = (r == 2) ? 200 : $urandom_range(1, 10);
      dv = $urandom_range(0, 3);
      m  = 1'($urandom_range(0, 1));
      nl = clamp_n(n);
      do_arm(n, dv, m);
      start_capture();
      feed_capture(nl * (dv + 1) * 2 + 50);
      check("rand_stream_len", 32'(stream_q.size()), 32'((nl - 1) * (dv + 1) + 1));
      build_expected(dv, nl, m);
      read_all(0, 0, 60);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_capture_buffer.md
Name: adc_capture_buffer

Overview:
- Parametrised successor to the fixed 120-sample ADC FIFO path of the Doppler front end.
- Arms on command and starts on the trigger rising edge from the state handler.
- Captures a programmable number of decimated ADC samples into on-chip RAM, then presents them as 8- or 16-bit words over a valid/ready read port for the SPI/SSP output stage.
- Drives the host data-ready flag; supports abort at any time.

Parameters:
- ADC_W, 14, ADC sample width (1..16).
- DEPTH, 128, buffer depth in samples (power of two, 2..4096).
- AW, $clog2(DEPTH), address width (derived).
- DECIM_W, 8, width of decimation field.

Ports:
- mainclk  in  1  system clock; all logic on rising edge.
- rstb  in  1  asynchronous, active-low reset.
- arm  in  1  one-cycle pulse; accepted only in IDLE.
- abort  in  1  synchronous abort, any state.
- trigger  in  1  level from state handler, synchronous to mainclk.
- adc_valid  in  1  one-cycle strobe per converted sample.
- adc_data  in  ADC_W  sample, valid with adc_valid.
- decim  in  DECIM_W  keep one sample in (decim+1); latched on arm.
- n_samples  in  AW+1  samples to capture; latched on arm.
- out_mode  in  1  0 = 16-bit words, 1 = 8-bit bytes; latched on arm.
- rd_ready  in  1  consumer ready.
- rd_valid  out  1  rd_data valid.
- rd_data  out  16  output word.
- data_ready  out  1  buffer filled, readout pending or in progress.
- state  out  2  current FSM state.
- arm_err  out  1  sticky: arm seen outside IDLE.

Behaviour:
- Reset values: rd_valid 0, rd_data 0, data_ready 0, state IDLE (0), arm_err 0, all pointers and counters 0.
- States: IDLE=0, ARMED=1, CAPTURE=2, READOUT=3.
- IDLE:
  - arm latches decim, out_mode, and n_samples; next state ARMED.
  - n_samples of 0 or > DEPTH clamps to DEPTH.
- ARMED:
  - trigger registered each cycle.
  - trigger 0->1 edge enters CAPTURE with wr_ptr=0 and decimation counter=0.
  - A trigger already high at arm does not start capture; a fresh edge is required.
- CAPTURE:
  - Each adc_valid with decimation counter == 0 writes adc_data at wr_ptr, increments wr_ptr, and reloads the counter with decim.
  - Otherwise adc_valid decrements the counter. The first adc_valid after entry is always written.
  - The cycle after the n-th write: READOUT, data_ready=1.
  - Trigger level is ignored during CAPTURE.
- READOUT:
  - RAM has a synchronous read with 1-cycle latency.
  - rd_valid rises 2 cycles after entering READOUT.
  - A word transfers on rd_valid & rd_ready. rd_valid then drops for exactly 1 cycle while the next word is fetched, giving a maximum of 1 word per 2 cycles.
  - rd_data and rd_valid are held stable while rd_valid=1 and rd_ready=0.
  - 16-bit mode: rd_data = sample zero-extended; n words.
  - 8-bit mode: rd_data[15:8]=0. Each sample gives two words, high byte first ({zero-extended sample}[15:8]), then low byte; 2n words.
  - After the last transfer: IDLE, data_ready=0, rd_valid=0 on the same edge.
- abort (highest priority, any state):
  - Next edge: IDLE, rd_valid=0, data_ready=0, pointers cleared, arm_err cleared.
  - abort and arm in the same cycle: abort wins, arm is ignored.
- arm outside IDLE: ignored and sets arm_err. arm_err is cleared only by abort or reset.
- Asynchronous reset mid-capture or mid-readout discards the buffer. RAM contents are not cleared but are never output stale.
- Each capture overwrites from address 0, so no wrap-around.

Optional Feature:
- Macro CAPTURE_HEADER_EN.
- Defined: readout begins with one header word before the samples.
  - Header = {out_mode, 3'b101, n_latched[11:0]}, where n_latched is the latched n_samples after clamping, zero-extended into bits [11:0].
  - In 8-bit mode the header is sent as two bytes, high byte first.
  - Word counts become n+1 (16-bit) or 2n+2 (8-bit).
- Undefined: no header; the first word is sample 0.

Test Plan:
- Basic 16-bit capture: arm with n=4, decim=0, out_mode=0. Trigger rises, then adc_data 0x0001, 0x0002, 0x3FFF, 0x2000 → data_ready=1; rd_ready=1 reads 0x0001, 0x0002, 0x3FFF, 0x2000 with one idle cycle between words, then state=0 and data_ready=0.
- Decimation and 8-bit mode: decim=2, n=2, out_mode=1, adc samples 0x1234, 1, 2, 0x0ABC, 3 → bytes 0x12, 0x34, 0x0A, 0xBC.
- Backpressure: hold rd_ready=0 for 10 cycles in READOUT → rd_valid stays 1 and rd_data is stable; release → transfer on the first ready cycle.
- Trigger already high at arm: no capture until trigger goes 0 then 1. Arm pulse during CAPTURE → arm_err=1, capture unaffected.
- Abort after 2 of 4 samples, and separately mid-readout → state=0, data_ready=0, rd_valid=0 next cycle, arm_err=0. A new arm with n=0 then captures DEPTH=128 samples.
- CAPTURE_HEADER_EN defined, n=3, out_mode=0 → first word 0x5003, then 3 samples.
